// File: rtl/mul_div_unit_pkg.sv
//----------------------------------------------------------------------
// mul_div_unit_pkg : shared CPU definitions for the HI/LO multiply-divide unit
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  localparam int MUL_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT = 10;

  // Multi-cycle ops are the ones that occupy the unit and stall the pipe.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit.sv
//----------------------------------------------------------------------
// mul_div_unit : HI/LO multiply-divide unit with fixed, parameterised latency
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall_req
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [31:0]      hi, lo, hi_n, lo_n;
  logic [CNT_W-1:0] cnt;
  logic             commit_en;

  logic             long_op;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      divisor, a_mag, b_mag;
  logic [31:0]      uq, ur, mq, mr, sq, sr;
  logic [31:0]      stage_hi, stage_lo;
  logic [CNT_W-1:0] stage_lat;
  logic             stage_div0;

  assign long_op   = is_long_op(op);
  assign stall_req = busy | (start & long_op);
  assign rd_data   = rd_sel ? hi : lo;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide-by-zero uses a dummy divisor; its result is discarded at commit.
  assign divisor = (b == 32'd0) ? 32'd1 : b;
  assign uq      = a / divisor;
  assign ur      = a % divisor;

  // Signed divide through magnitudes, so 0x80000000 / -1 needs no special case.
  assign a_mag = a[31] ? (32'd0 - a) : a;
  assign b_mag = divisor[31] ? (32'd0 - divisor) : divisor;
  assign mq    = a_mag / b_mag;
  assign mr    = a_mag % b_mag;
  assign sq    = (a[31] ^ divisor[31]) ? (32'd0 - mq) : mq;
  assign sr    = a[31] ? (32'd0 - mr) : mr;

  always_comb begin
    stage_hi   = 32'd0;
    stage_lo   = 32'd0;
    stage_lat  = '0;
    stage_div0 = 1'b0;
    case (op)
      OP_MULT: begin
        {stage_hi, stage_lo} = prod_s;
        stage_lat            = CNT_W'(MUL_LAT);
      end
      OP_MULTU: begin
        {stage_hi, stage_lo} = prod_u;
        stage_lat            = CNT_W'(MUL_LAT);
      end
      OP_DIV: begin
        stage_hi   = sr;
        stage_lo   = sq;
        stage_lat  = CNT_W'(DIV_LAT);
        stage_div0 = (b == 32'd0);
      end
      OP_DIVU: begin
        stage_hi   = ur;
        stage_lo   = uq;
        stage_lat  = CNT_W'(DIV_LAT);
        stage_div0 = (b == 32'd0);
      end
      default: begin
        stage_hi = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      hi_n      <= 32'd0;
      lo_n      <= 32'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      commit_en <= 1'b0;
    end else if (busy) begin
      // Any start seen while busy is dropped here by construction.
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        if (commit_en) begin
          hi <= hi_n;
          lo <= lo_n;
        end
      end
    end else if (start) begin
      if (long_op) begin
        hi_n      <= stage_hi;
        lo_n      <= stage_lo;
        cnt       <= stage_lat;
        busy      <= 1'b1;
        commit_en <= ~stage_div0;
      end else if (op == OP_MTHI) begin
        hi <= a;
      end else if (op == OP_MTLO) begin
        lo <= a;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
//----------------------------------------------------------------------
// tb_mul_div_unit : directed plus random checks of mul_div_unit against an
// arithmetic HI/LO model
//----------------------------------------------------------------------
`default_nettype none

module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset, start, rd_sel;
  logic [2:0]  op;
  logic [31:0] a, b, rd_data;
  logic        busy, stall_req;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mul_div_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    rd_sel = 1'b0; #1;
    check({tag, "_lo"}, rd_data, exp_lo);
    rd_sel = 1'b1; #1;
    check({tag, "_hi"}, rd_data, exp_hi);
    rd_sel = 1'b0;
  endtask

  // Issue one op; optionally re-strobe start at busy cycle inj (must be ignored).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int inj);
    logic   is_long, upd;
    logic [63:0] r;
    longint sx, sy, q, rm;
    int     lat;
    is_long = (o <= 3'd3);
    upd     = 1'b1;
    r       = 64'd0;
    sx      = longint'($signed(x));
    sy      = longint'($signed(y));
    case (o)
      3'd0: r = 64'(sx * sy);
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: if (y == 32'd0) upd = 1'b0;
            else begin q = sx / sy; rm = sx % sy; r = {rm[31:0], q[31:0]}; end
      3'd3: if (y == 32'd0) upd = 1'b0;
            else r = {x % y, x / y};
      default: upd = 1'b0;
    endcase
    lat = (o <= 3'd1) ? MUL_LAT : DIV_LAT;

    start = 1'b1; op = o; a = x; b = y; #1;
    check("stall_at_issue", {31'd0, stall_req}, {31'd0, is_long});
    tick();
    start = 1'b0; a = $urandom; b = $urandom;

    if (!is_long) begin
      if (o == 3'd4) m_hi = x;
      if (o == 3'd5) m_lo = x;
      check("busy_short_op", {31'd0, busy}, 32'd0);
      read_check("short_op", m_hi, m_lo);
      return;
    end

    for (int k = 1; k <= lat; k++) begin
      check("busy_in_flight", {31'd0, busy}, 32'd1);
      check("stall_in_flight", {31'd0, stall_req}, 32'd1);
      check("rd_before_commit", rd_data, m_lo);
      if (k == inj) begin
        start = 1'b1; op = OP_MULT; a = $urandom; b = $urandom;
      end
      tick();
      start = 1'b0;
    end
    if (upd) {m_hi, m_lo} = r;
    check("busy_after_commit", {31'd0, busy}, 32'd0);
    read_check("commit", m_hi, m_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd_sel = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stall", {31'd0, stall_req}, 32'd0);
    read_check("reset", 32'd0, 32'd0);

    // stall_req is purely combinational on start/op when idle
    start = 1'b1; op = OP_MTHI; #1;
    check("stall_mthi", {31'd0, stall_req}, 32'd0);
    op = OP_DIV; #1;
    check("stall_div", {31'd0, stall_req}, 32'd1);
    op = 3'd7; #1;
    check("stall_undef", {31'd0, stall_req}, 32'd0);
    start = 1'b0;
    tick();

    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 0);
    read_check("mult_neg2x3", 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 0);
    read_check("multu", 32'h00000001, 32'hFFFFFFFE);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
    read_check("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(OP_DIVU, 32'd7, 32'd0, 0);
    read_check("divu_by0", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(OP_MTHI, 32'h12345678, 32'd0, 0);
    read_check("mthi", 32'h12345678, 32'hFFFFFFFD);
    run_op(OP_MULT, 32'd1000, 32'hFFFFFFFF, 2);
    read_check("mult_ignore_restart", 32'hFFFFFFFF, 32'hFFFFFC18);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, MUL_LAT);
    read_check("div_overflow", 32'd0, 32'h80000000);
    run_op(OP_MTLO, 32'hCAFEF00D, 32'd0, 0);
    run_op(3'd6, 32'h55555555, 32'd1, 0);
    run_op(3'd7, 32'hAAAAAAAA, 32'd1, 0);
    read_check("undef_noop", 32'd0, 32'hCAFEF00D);

    // back-to-back: DIVU issued in the cycle right after the MULT commits
    run_op(OP_MULT, 32'd123456, 32'd654321, 0);
    run_op(OP_DIVU, 32'hFFFFFFF0, 32'd7, 0);
    read_check("b2b_divu", 32'hFFFFFFF0 % 32'd7, 32'hFFFFFFF0 / 32'd7);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      int          rinj;
      ro   = 3'($urandom_range(0, 7));
      rx   = $urandom;
      ry   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($signed($urandom_range(0, 9)) - 5);
      rinj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, MUL_LAT) : 0;
      run_op(ro, rx, ry, rinj);
    end

    // reset during a divide aborts it with no later commit
    run_op(OP_MTHI, 32'hDEADBEEF, 32'd0, 0);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    read_check("abort", 32'd0, 32'd0);
    for (int k = 0; k < DIV_LAT + 2; k++) begin
      tick();
      check("abort_no_busy", {31'd0, busy}, 32'd0);
    end
    read_check("abort_no_commit", 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
